// File: rtl/store_buffer_lsu_if.sv
// Datapath/memory-side bundle of the store-buffered load/store unit.
// The LSU takes the slave view; the datapath/memory environment takes the master view.
interface store_buffer_lsu_if #(
    parameter int unsigned Depth = 4
);
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic            st_valid;
    logic [15:0]     st_addr;
    logic [15:0]     st_data;
    logic            st_ready;
    logic            ld_valid;
    logic [15:0]     ld_addr;
    logic [15:0]     ld_data;
    logic            ld_stall;
    logic            buf_empty;
    logic [CntW-1:0] buf_count;
    logic [15:0]     mem_access_addr;
    logic [15:0]     mem_write_data;
    logic            mem_write_en;
    logic            mem_read;
    logic [15:0]     mem_read_data;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
        input  st_ready, ld_data, ld_stall, buf_empty, buf_count,
        input  mem_access_addr, mem_write_data, mem_write_en, mem_read
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
        output st_ready, ld_data, ld_stall, buf_empty, buf_count,
        output mem_access_addr, mem_write_data, mem_write_en, mem_read
    );
endinterface

// File: rtl/store_buffer_lsu.sv
// Store-buffered load/store front-end owning the single data-memory port.
// Loads win the port over draining stores and forward from the youngest matching queued store.
module store_buffer_lsu #(
    parameter int unsigned Depth       = 4,
    parameter int unsigned AddrCmpBits = 3
) (
    input logic               clk_i,
    input logic               reset_i,
    store_buffer_lsu_if.slave bus_io
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [15:0]      addr_q [Depth];
    logic [15:0]      data_q [Depth];
    logic [Depth-1:0] valid_q, valid_d;
    logic [PtrW-1:0]  head_q, head_d;
    logic [PtrW-1:0]  tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;

    logic             full;
    logic             push;
    logic             pop;
    logic             drain_sel;
    logic             ld_sel;
    logic             stall;
    logic             fwd_hit;
    logic [15:0]      fwd_data;
    logic [PtrW-1:0]  fwd_idx;

    assign full = (count_q == CntW'(Depth));

    // Port arbitration: a full buffer drains even under a load so the pipeline cannot deadlock.
    always_comb begin
        stall     = 1'b0;
        ld_sel    = 1'b0;
        drain_sel = 1'b0;
        if (full && bus_io.ld_valid) begin
            stall     = 1'b1;
            drain_sel = 1'b1;
        end else if (bus_io.ld_valid) begin
            ld_sel = 1'b1;
        end else if (count_q != '0) begin
            drain_sel = 1'b1;
        end
    end

    // A reset edge must not commit the head entry to memory.
    assign pop  = drain_sel && !reset_i;
    assign push = bus_io.st_valid && !full;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            addr_q[tail_q] <= bus_io.st_addr;
            data_q[tail_q] <= bus_io.st_data;
        end
    end

    // Walk oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head_q;
        for (int unsigned k = 0; k < Depth; k++) begin
            fwd_idx = head_q + PtrW'(k);
            if (valid_q[fwd_idx] &&
                (addr_q[fwd_idx][AddrCmpBits-1:0] == bus_io.ld_addr[AddrCmpBits-1:0])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    always_comb begin
        bus_io.mem_read        = ld_sel;
        bus_io.mem_write_en    = pop;
        bus_io.mem_access_addr = '0;
        bus_io.mem_write_data  = '0;
        bus_io.ld_data         = '0;
        if (drain_sel) begin
            bus_io.mem_access_addr = addr_q[head_q];
            bus_io.mem_write_data  = data_q[head_q];
        end else if (ld_sel) begin
            bus_io.mem_access_addr = bus_io.ld_addr;
        end
        if (ld_sel) begin
            bus_io.ld_data = fwd_hit ? fwd_data : bus_io.mem_read_data;
        end
    end

    assign bus_io.ld_stall  = stall;
    assign bus_io.st_ready  = !full;
    assign bus_io.buf_empty = (count_q == '0);
    assign bus_io.buf_count = count_q;

endmodule

// File: tb/tb_store_buffer_lsu.sv
// Randomized bench for store_buffer_lsu: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_store_buffer_lsu;
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } st_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    logic [15:0] dev_mem [8] = '{16'hE000, 16'hE001, 16'hE002, 16'hE003,
                                 16'hE004, 16'hE005, 16'hE006, 16'hE007};
    logic [15:0] ref_mem [8] = '{16'hE000, 16'hE001, 16'hE002, 16'hE003,
                                 16'hE004, 16'hE005, 16'hE006, 16'hE007};
    st_t q [$];
    bit  armed = 1'b0;

    store_buffer_lsu_if #(.Depth(4)) bus ();

    store_buffer_lsu #(
        .Depth      (4),
        .AddrCmpBits(3)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    // Data memory decodes only the low 3 address bits, combinational read.
    assign bus.mem_read_data = dev_mem[bus.mem_access_addr[2:0]];
    always @(posedge clk) begin
        if (bus.mem_write_en) dev_mem[bus.mem_access_addr[2:0]] <= bus.mem_write_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs from the queue contents and current inputs, then advance one edge.
    always @(negedge clk) begin : model
        int          n;
        bit          full;
        bit          drain;
        bit          found;
        logic [15:0] fwd;
        n    = q.size();
        full = (n == 4);
        if (armed) begin
            chk("st_ready", 32'(bus.st_ready), 32'(!full));
            chk("buf_empty", 32'(bus.buf_empty), 32'(n == 0));
            chk("buf_count", 32'(bus.buf_count), 32'(n));
            if (full && bus.ld_valid) begin
                chk("stall", 32'(bus.ld_stall), 32'd1);
                chk("mem_read", 32'(bus.mem_read), 32'd0);
                chk("we", 32'(bus.mem_write_en), 32'(!rst));
                chk("waddr", 32'(bus.mem_access_addr), 32'(q[0].a));
                chk("wdata", 32'(bus.mem_write_data), 32'(q[0].d));
                chk("ld_data", 32'(bus.ld_data), 32'd0);
            end else if (bus.ld_valid) begin
                found = 1'b0;
                fwd   = ref_mem[bus.ld_addr[2:0]];
                for (int i = n - 1; i >= 0; i--) begin
                    if (!found && q[i].a[2:0] == bus.ld_addr[2:0]) begin
                        found = 1'b1;
                        fwd   = q[i].d;
                    end
                end
                chk("stall", 32'(bus.ld_stall), 32'd0);
                chk("mem_read", 32'(bus.mem_read), 32'd1);
                chk("we", 32'(bus.mem_write_en), 32'd0);
                chk("raddr", 32'(bus.mem_access_addr), 32'(bus.ld_addr));
                chk("ld_data", 32'(bus.ld_data), 32'(fwd));
            end else if (n != 0) begin
                chk("stall", 32'(bus.ld_stall), 32'd0);
                chk("mem_read", 32'(bus.mem_read), 32'd0);
                chk("we", 32'(bus.mem_write_en), 32'(!rst));
                chk("waddr", 32'(bus.mem_access_addr), 32'(q[0].a));
                chk("wdata", 32'(bus.mem_write_data), 32'(q[0].d));
                chk("ld_data", 32'(bus.ld_data), 32'd0);
            end else begin
                chk("idle_bus", {bus.ld_stall, bus.mem_read, bus.mem_write_en,
                                 bus.mem_access_addr, 13'd0}, 32'd0);
                chk("idle_wdata", 32'(bus.mem_write_data), 32'd0);
                chk("ld_data", 32'(bus.ld_data), 32'd0);
            end
        end
        if (rst) begin
            q.delete();
            armed = 1'b1;
        end else if (armed) begin
            drain = (n != 0) && (full || !bus.ld_valid);
            if (drain) begin
                ref_mem[q[0].a[2:0]] = q[0].d;
                void'(q.pop_front());
            end
            if (bus.st_valid && !full) q.push_back('{a: bus.st_addr, d: bus.st_data});
        end
    end

    task automatic drive(input logic r, input logic sv, input logic [15:0] sa,
                         input logic [15:0] sd, input logic lv, input logic [15:0] la);
        @(posedge clk);
        #1;
        rst          = r;
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        bus.st_valid = 1'b0;
        bus.st_addr  = '0;
        bus.st_data  = '0;
        bus.ld_valid = 1'b0;
        bus.ld_addr  = '0;

        // In-order drain of three stores, one cycle minimum latency.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 16'd1, 16'h1111, 0, 0);
        settle();
        chk("t1_c0_we", 32'(bus.mem_write_en), 32'd0);
        drive(0, 1, 16'd2, 16'h2222, 0, 0);
        settle();
        chk("t1_c1_w", {bus.mem_write_en, bus.mem_access_addr[14:0], bus.mem_write_data},
            {1'b1, 15'd1, 16'h1111});
        drive(0, 1, 16'd3, 16'h3333, 0, 0);
        settle();
        chk("t1_c2_w", {bus.mem_write_en, bus.mem_access_addr[14:0], bus.mem_write_data},
            {1'b1, 15'd2, 16'h2222});
        drive(0, 0, 0, 0, 0, 0);
        settle();
        chk("t1_c3_w", {bus.mem_write_en, bus.mem_access_addr[14:0], bus.mem_write_data},
            {1'b1, 15'd3, 16'h3333});
        drive(0, 0, 0, 0, 0, 0);
        settle();
        chk("t1_c4_empty", {31'd0, bus.buf_empty}, 32'd1);

        // Youngest-match forwarding, load owns the port.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 16'd5, 16'hAAAA, 1, 16'h0020);
        drive(0, 1, 16'd5, 16'hBBBB, 1, 16'h0020);
        drive(0, 0, 0, 0, 1, 16'd5);
        settle();
        chk("t2_ld_data", 32'(bus.ld_data), 32'h0000_BBBB);
        chk("t2_port", {30'd0, bus.mem_read, bus.mem_write_en}, 32'd2);

        // Full buffer under load pressure: stall plus drain, refused store.
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 16'(16'h10 + i), 16'(16'hC000 + i), 1, 16'd7);
        drive(0, 1, 16'h0099, 16'hDEAD, 1, 16'd7);
        settle();
        chk("t3_stall", {29'd0, bus.ld_stall, bus.mem_write_en, bus.mem_read}, 32'd6);
        chk("t4_st_ready", {31'd0, bus.st_ready}, 32'd0);
        chk("t3_drain", {bus.mem_access_addr, bus.mem_write_data}, 32'h0010_C000);
        drive(0, 0, 0, 0, 1, 16'd7);
        settle();
        chk("t4_count", 32'(bus.buf_count), 32'd3);
        chk("t3_serviced", {30'd0, bus.ld_stall, bus.mem_read}, 32'd1);

        // Aliased low-bit forwarding.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 16'h0005, 16'h5A5A, 1, 16'h0010);
        drive(0, 0, 0, 0, 1, 16'h000D);
        settle();
        chk("t5_fwd", 32'(bus.ld_data), 32'h0000_5A5A);

        // Reset with queued stores discards them without writing memory.
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) drive(0, 1, 16'(i), 16'(16'h6000 + i), 1, 16'd0);
        drive(1, 0, 0, 0, 0, 0);
        settle();
        chk("t6_rst_we", 32'(bus.mem_write_en), 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        settle();
        chk("t6_after", {bus.buf_count, bus.mem_write_en, bus.buf_empty}, 32'h0000_0001);
        for (int i = 1; i <= 3; i++) drive(0, 0, 0, 0, 1, 16'(i));

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] sa;
            logic [15:0] la;
            sa = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            la = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1), sa,
                  16'($urandom), ($urandom_range(0, 9) < 4), la);
        end
        drive(0, 0, 0, 0, 0, 0);
        settle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
